// File: rtl/tv_grad_dx_if.sv
// Bus between the dx engine and its environment: start/busy/done control plus
// the frame-BRAM read port and gradient-BRAM write port. master = engine side.
interface tv_grad_dx_if #(
  parameter int PORT_SIZE = 32,
  parameter int DATA_W    = 16,
  parameter int FNUM_W    = 7,
  parameter int ADDR_W    = 16
);
  logic                        start;
  logic [FNUM_W-1:0]           f_num;
  logic                        busy;
  logic                        done;
  logic                        ren;
  logic [ADDR_W-1:0]           raddr;
  logic [PORT_SIZE*DATA_W-1:0] din;
  logic                        wen;
  logic [ADDR_W-1:0]           waddr;
  logic [PORT_SIZE*DATA_W-1:0] dout;

  modport master (
    input  start, f_num, din,
    output busy, done, ren, raddr, wen, waddr, dout
  );

  modport slave (
    output start, f_num, din,
    input  busy, done, ren, raddr, wen, waddr, dout
  );
endinterface

// File: rtl/tv_grad_dx.sv
// Horizontal forward-difference engine for GAP-TV: streams a frame word by word,
// writes dx = right neighbour - pixel. Define TV_GRAD_SAT_EN to saturate results.
module tv_grad_dx #(
  parameter int PORT_SIZE = 32,
  parameter int DATA_W    = 16,
  parameter int COL_WIDTH = 2,
  parameter int ROW_NUM   = 48,
  parameter int FNUM_W    = 7,
  parameter int ADDR_W    = 16,
  parameter int BOUNDARY  = 0
) (
  input  logic         clk,
  input  logic         rst,
  tv_grad_dx_if.master bus
);

  localparam int COL_W  = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
  localparam int ROW_W  = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam int WORD_W = PORT_SIZE * DATA_W;
  localparam logic [ADDR_W-1:0] FRAME_WORDS = ADDR_W'(ROW_NUM * COL_WIDTH);
  localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(COL_WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(ROW_NUM - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                drain_q, drain_d;
  logic                ren_q, ren_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d;
  logic                rs_q, rs_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                v1_q, v1_d;
  logic [ADDR_W-1:0]   a1_q, a1_d;
  logic                rs1_q, rs1_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                wen_q, wen_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0]   dout_q, dout_d;
  logic [WORD_W-1:0]   res;
  logic [DATA_W:0]     diff [PORT_SIZE];

  function automatic logic [DATA_W-1:0] reduce(input logic [DATA_W:0] d);
`ifdef TV_GRAD_SAT_EN
    if (d[DATA_W] != d[DATA_W-1])
      reduce = d[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      reduce = d[DATA_W-1:0];
`else
    reduce = d[DATA_W-1:0];
`endif
  endfunction

  // base_q is the address of column 0 of the current row; col scans downward
  // so the right-hand word (prev) has always been seen first.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    base_d  = base_q;
    drain_d = drain_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_READ;
          row_d   = '0;
          col_d   = COL_LAST;
          base_d  = ADDR_W'(bus.f_num) * FRAME_WORDS;
        end
      end
      S_READ: begin
        if (col_q == '0) begin
          if (row_q == ROW_LAST) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end else begin
            row_d  = row_q + 1'b1;
            col_d  = COL_LAST;
            base_d = base_q + ADDR_W'(COL_WIDTH);
          end
        end else begin
          col_d = col_q - 1'b1;
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ren_d   = (state_d == S_READ);
    raddr_d = ren_d ? base_d + ADDR_W'(col_d) : '0;
    rs_d    = ren_d && (col_d == COL_LAST);
    busy_d  = (state_d == S_READ) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);

    v1_d    = ren_q;
    a1_d    = raddr_q;
    rs1_d   = rs_q;
    wen_d   = v1_q;
    waddr_d = v1_q ? a1_q : '0;
    dout_d  = v1_q ? res : '0;
    prev_d  = v1_q ? bus.din[DATA_W-1:0] : prev_q;
  end

  // Operands sign-extended by one bit so the difference never overflows before reduction.
  for (genvar gi = 0; gi < PORT_SIZE; gi++) begin : g_lane
    logic [DATA_W:0] cur_w;
    logic [DATA_W:0] nb_w;
    assign cur_w = {bus.din[gi*DATA_W + DATA_W-1], bus.din[gi*DATA_W +: DATA_W]};
    if (gi < PORT_SIZE - 1) begin : g_inner
      assign nb_w = {bus.din[(gi+1)*DATA_W + DATA_W-1], bus.din[(gi+1)*DATA_W +: DATA_W]};
    end else begin : g_edge
      assign nb_w = rs1_q ? '0 : {prev_q[DATA_W-1], prev_q};
    end
    assign diff[gi] = nb_w - cur_w;
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < PORT_SIZE; i++) res[i*DATA_W +: DATA_W] = reduce(diff[i]);
    if (BOUNDARY == 1 && rs1_q) res[WORD_W-1 -: DATA_W] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      base_q  <= '0;
      drain_q <= 1'b0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
      rs_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      rs1_q   <= 1'b0;
      prev_q  <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      base_q  <= base_d;
      drain_q <= drain_d;
      ren_q   <= ren_d;
      raddr_q <= raddr_d;
      rs_q    <= rs_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      v1_q    <= v1_d;
      a1_q    <= a1_d;
      rs1_q   <= rs1_d;
      prev_q  <= prev_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.ren   = ren_q;
  assign bus.raddr = raddr_q;
  assign bus.wen   = wen_q;
  assign bus.waddr = waddr_q;
  assign bus.dout  = dout_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_tv_grad_dx.sv
// Bench for tv_grad_dx: BOUNDARY=0/1 engines plus a one-word-frame engine share a
// BRAM model; a read-time scoreboard checks every write, tables check known words.
module tb_tv_grad_dx;
  localparam int P = 4, DW = 16, C = 2, R = 3, FW = 7, AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [FW-1:0] f_num = '0;
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  tv_grad_dx_if #(.PORT_SIZE(P), .DATA_W(DW), .FNUM_W(FW), .ADDR_W(AW)) bus0 ();
  tv_grad_dx_if #(.PORT_SIZE(P), .DATA_W(DW), .FNUM_W(FW), .ADDR_W(AW)) bus1 ();
  tv_grad_dx_if #(.PORT_SIZE(P), .DATA_W(DW), .FNUM_W(FW), .ADDR_W(AW)) bus2 ();

  assign bus0.start = start;
  assign bus1.start = start;
  assign bus2.start = start;
  assign bus0.f_num = f_num;
  assign bus1.f_num = f_num;
  assign bus2.f_num = f_num;

  tv_grad_dx #(.PORT_SIZE(P), .DATA_W(DW), .COL_WIDTH(C), .ROW_NUM(R), .FNUM_W(FW),
               .ADDR_W(AW), .BOUNDARY(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.master));
  tv_grad_dx #(.PORT_SIZE(P), .DATA_W(DW), .COL_WIDTH(C), .ROW_NUM(R), .FNUM_W(FW),
               .ADDR_W(AW), .BOUNDARY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.master));
  tv_grad_dx #(.PORT_SIZE(P), .DATA_W(DW), .COL_WIDTH(1), .ROW_NUM(1), .FNUM_W(FW),
               .ADDR_W(AW), .BOUNDARY(0)) dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  logic [63:0] mem  [1024];
  logic [63:0] cap0 [1024];
  logic [63:0] cap1 [1024];

  always @(posedge clk) begin
    if (bus0.ren) bus0.din <= mem[bus0.raddr[9:0]];
    if (bus1.ren) bus1.din <= mem[bus1.raddr[9:0]];
    if (bus2.ren) bus2.din <= mem[bus2.raddr[9:0]];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] red(input int d);
    int v;
    v = d;
`ifdef TV_GRAD_SAT_EN
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
`endif
    return v[15:0];
  endfunction

  // Reference: neighbour of lane i is lane i+1; lane 3 takes lane 0 of the word
  // at addr+1 unless this word starts the row.
  function automatic logic [63:0] model(input int addr, input bit bnd, input bit rs);
    logic [63:0] w, nxt, r;
    int a, b;
    w = mem[addr];
    r = '0;
    for (int i = 0; i < 3; i++) begin
      a = int'($signed(w[i*16 +: 16]));
      b = int'($signed(w[(i+1)*16 +: 16]));
      r[i*16 +: 16] = red(b - a);
    end
    a = int'($signed(w[63:48]));
    if (rs) begin
      r[63:48] = bnd ? 16'h0000 : red(-a);
    end else begin
      nxt = mem[addr + 1];
      r[63:48] = red(int'($signed(nxt[15:0])) - a);
    end
    return r;
  endfunction

  function automatic logic [63:0] pk(input int l0, input int l1, input int l2, input int l3);
    return {l3[15:0], l2[15:0], l1[15:0], l0[15:0]};
  endfunction

  typedef struct packed {
    logic [15:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  always @(negedge clk) begin
    exp_t e;
    if (bus0.ren) begin
      e.addr = bus0.raddr;
      e.data = model(int'(bus0.raddr), 1'b0, bus0.raddr[0]);
      q0.push_back(e);
    end
    if (bus1.ren) begin
      e.addr = bus1.raddr;
      e.data = model(int'(bus1.raddr), 1'b1, bus1.raddr[0]);
      q1.push_back(e);
    end
    if (bus0.wen) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0_unexpected: write addr %0d, expected no write", bus0.waddr);
      end else begin
        e = q0.pop_front();
        check("sb0_waddr", 64'(bus0.waddr), 64'(e.addr));
        check("sb0_dout", bus0.dout, e.data);
        $display("dut0 write addr=%0d data=%h", bus0.waddr, bus0.dout);
      end
      cap0[bus0.waddr[9:0]] = bus0.dout;
    end
    if (bus1.wen) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb1_unexpected: write addr %0d, expected no write", bus1.waddr);
      end else begin
        e = q1.pop_front();
        check("sb1_waddr", 64'(bus1.waddr), 64'(e.addr));
        check("sb1_dout", bus1.dout, e.data);
        $display("dut1 write addr=%0d data=%h", bus1.waddr, bus1.dout);
      end
      cap1[bus1.waddr[9:0]] = bus1.dout;
    end
    if (rst) begin
      q0.delete();
      q1.delete();
    end
  end

  task automatic run_frame(input logic [FW-1:0] f, input string tag);
    bit seen0, seen1;
    seen0 = 1'b0;
    seen1 = 1'b0;
    @(posedge clk); #1; f_num = f; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 40 && !(seen0 && seen1); c++) begin
      @(negedge clk);
      if (bus0.done) seen0 = 1'b1;
      if (bus1.done) seen1 = 1'b1;
    end
    check({tag, "_done0"}, 64'(seen0), 64'd1);
    check({tag, "_done1"}, 64'(seen1), 64'd1);
  endtask

  typedef struct {
    logic [FW-1:0] f;
    logic [63:0]   w1, w0, r1;
    logic [63:0]   e1_b0, e1_b1, e0, er1_b0, er1_b1;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [3];
    logic [15:0] seq [6];
    int          base;

    seq = '{16'd13, 16'd12, 16'd15, 16'd14, 16'd17, 16'd16};
    vecs[0] = '{f: 7'd2, w1: pk(10, 20, 30, 40), w0: pk(1, 2, 3, 4), r1: pk(7, 7, 7, 100),
                e1_b0: pk(10, 10, 10, -40), e1_b1: pk(10, 10, 10, 0), e0: pk(1, 1, 1, 6),
                er1_b0: pk(0, 0, 93, -100), er1_b1: pk(0, 0, 93, 0)};
`ifdef TV_GRAD_SAT_EN
    vecs[1] = '{f: 7'd5, w1: pk(-32768, 32767, 0, 0), w0: pk(32767, -32768, 5, -32768),
                r1: pk(0, 0, 0, -32768),
                e1_b0: pk(32767, -32767, 0, 0), e1_b1: pk(32767, -32767, 0, 0),
                e0: pk(-32768, 32767, -32768, 0),
                er1_b0: pk(0, 0, -32768, 32767), er1_b1: pk(0, 0, -32768, 0)};
`else
    vecs[1] = '{f: 7'd5, w1: pk(-32768, 32767, 0, 0), w0: pk(32767, -32768, 5, -32768),
                r1: pk(0, 0, 0, -32768),
                e1_b0: pk(-1, -32767, 0, 0), e1_b1: pk(-1, -32767, 0, 0),
                e0: pk(1, -32763, 32763, 0),
                er1_b0: pk(0, 0, -32768, -32768), er1_b1: pk(0, 0, -32768, 0)};
`endif
    vecs[2] = '{f: 7'd127, w1: pk(-1, -1, -1, -1), w0: pk(0, 0, 0, 0), r1: pk(3, 2, 1, 0),
                e1_b0: pk(0, 0, 0, 1), e1_b1: pk(0, 0, 0, 0), e0: pk(0, 0, 0, -1),
                er1_b0: pk(-1, -1, -1, 0), er1_b1: pk(-1, -1, -1, 0)};

    for (int i = 0; i < 1024; i++) mem[i] = {$urandom, $urandom};
    for (int v = 0; v < 3; v++) begin
      base = int'(vecs[v].f) * (R * C);
      mem[base + 1] = vecs[v].w1;
      mem[base]     = vecs[v].w0;
      mem[base + 3] = vecs[v].r1;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ren",   64'(bus0.ren),   64'd0);
    check("rst_wen",   64'(bus0.wen),   64'd0);
    check("rst_busy",  64'(bus0.busy),  64'd0);
    check("rst_done",  64'(bus0.done),  64'd0);
    check("rst_raddr", 64'(bus0.raddr), 64'd0);
    check("rst_waddr", 64'(bus0.waddr), 64'd0);
    check("rst_dout",  bus0.dout,       64'd0);
    check("rst_busy1", 64'(bus1.busy),  64'd0);
    @(posedge clk); #1; rst = 1'b0;

    // Addressing/timing, start-while-busy ignored, one-word frame engine alongside
    @(posedge clk); #1; f_num = 7'd2; start = 1'b1;
    @(posedge clk); #1; start = 1'b0; f_num = 7'd9;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("a_c%0d_ren", c), 64'(bus0.ren), 64'(c <= 6));
      if (c <= 6) check($sformatf("a_c%0d_raddr", c), 64'(bus0.raddr), 64'(seq[c-1]));
      check($sformatf("a_c%0d_wen", c), 64'(bus0.wen), 64'(c >= 3 && c <= 8));
      if (c >= 3 && c <= 8) check($sformatf("a_c%0d_waddr", c), 64'(bus0.waddr), 64'(seq[c-3]));
      check($sformatf("a_c%0d_busy", c), 64'(bus0.busy), 64'(c <= 8));
      check($sformatf("a_c%0d_done", c), 64'(bus0.done), 64'(c == 9));
      check($sformatf("s_c%0d_ren", c), 64'(bus2.ren), 64'(c == 1));
      check($sformatf("s_c%0d_wen", c), 64'(bus2.wen), 64'(c == 3));
      check($sformatf("s_c%0d_done", c), 64'(bus2.done), 64'(c == 4));
      check($sformatf("s_c%0d_busy", c), 64'(bus2.busy), 64'(c <= 3));
      if (c == 1) check("s_raddr", 64'(bus2.raddr), 64'd2);
      if (c == 3) check("s_dout", bus2.dout, model(2, 1'b0, 1'b1));
      if (c == 3) begin start = 1'b1; f_num = 7'd9; end
      if (c == 4) start = 1'b0;
    end

    // Table of known words: boundary modes, overflow, row chaining
    for (int v = 0; v < 3; v++) begin
      run_frame(vecs[v].f, $sformatf("vec%0d", v));
      base = int'(vecs[v].f) * (R * C);
      check($sformatf("vec%0d_r0c1_b0", v), cap0[base + 1], vecs[v].e1_b0);
      check($sformatf("vec%0d_r0c1_b1", v), cap1[base + 1], vecs[v].e1_b1);
      check($sformatf("vec%0d_r0c0_b0", v), cap0[base],     vecs[v].e0);
      check($sformatf("vec%0d_r0c0_b1", v), cap1[base],     vecs[v].e0);
      check($sformatf("vec%0d_r1c1_b0", v), cap0[base + 3], vecs[v].er1_b0);
      check($sformatf("vec%0d_r1c1_b1", v), cap1[base + 3], vecs[v].er1_b1);
    end

    // Reset in cycle 4 of a frame
    @(posedge clk); #1; f_num = 7'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      rst = (c == 4);
      @(negedge clk);
      if (c >= 5) begin
        check($sformatf("r_c%0d_wen", c),  64'(bus0.wen),  64'd0);
        check($sformatf("r_c%0d_ren", c),  64'(bus0.ren),  64'd0);
        check($sformatf("r_c%0d_busy", c), 64'(bus0.busy), 64'd0);
        check($sformatf("r_c%0d_done", c), 64'(bus0.done), 64'd0);
      end else begin
        check($sformatf("r_c%0d_ren", c), 64'(bus0.ren), 64'd1);
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    run_frame(7'd5, "after_rst");

    // start coincident with reset
    @(posedge clk); #1; rst = 1'b1; start = 1'b1; f_num = 7'd3;
    @(posedge clk); #1; rst = 1'b0; start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check($sformatf("rs_c%0d_busy", c), 64'(bus0.busy), 64'd0);
      check($sformatf("rs_c%0d_ren", c),  64'(bus0.ren),  64'd0);
    end

    check("sb0_left", 64'(q0.size()), 64'd0);
    check("sb1_left", 64'(q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tv_grad_dx.md
Name: tv_grad_dx

Overview:
- Parametrised horizontal-gradient (dx) engine for the GAP-TV denoiser.
- Streams one frame from the frame BRAM, one PORT_SIZE-lane word per cycle, and computes the forward difference of each pixel against its right neighbour. Words are chained across word boundaries within a row.
- Writes the result word to the gradient BRAM at the same address.
- Controlled by a start/busy/done handshake. Adds frame selection, a boundary mode and saturation.

Parameters:
- PORT_SIZE, 32, pixels (lanes) per BRAM word.
- DATA_W, 16, bits per pixel, signed two's complement.
- COL_WIDTH, 2, words per row.
- ROW_NUM, 48, rows per frame.
- FNUM_W, 7, width of frame index.
- ADDR_W, 16, BRAM address width; must hold 2^FNUM_W*ROW_NUM*COL_WIDTH-1.
- BOUNDARY, 0, right-edge rule: 0 = neighbour treated as zero; 1 = replicate (edge diff forced to 0).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request; accepted only in IDLE.
- f_num  in  FNUM_W  frame index; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted through the last write.
- done  out  1  one-cycle pulse after the last write.
- ren  out  1  BRAM read enable.
- raddr  out  ADDR_W  BRAM read address.
- din  in  PORT_SIZE*DATA_W  read data, valid exactly 1 cycle after ren.
- wen  out  1  BRAM write enable.
- waddr  out  ADDR_W  BRAM write address.
- dout  out  PORT_SIZE*DATA_W  write data.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: all outputs 0. State=IDLE, counters 0, prev 0, pipeline valids 0.
- Lane i is bits [i*DATA_W +: DATA_W]. The neighbour of lane i is lane i+1 of the same word. The neighbour of lane PORT_SIZE-1 is lane 0 of the next-higher column word (prev).
- Address: f_num_q*ROW_NUM*COL_WIDTH + row*COL_WIDTH + col, computed in ADDR_W bits.
- Scan order: rows ascending. Within each row, col runs from COL_WIDTH-1 down to 0, so prev is already known when needed.
- States:
  - IDLE: start=1 -> READ; latch f_num, row=0, col=COL_WIDTH-1.
  - READ: ren=1 every cycle, raddr per formula. col decrements each cycle. At col=0: col reloads to COL_WIDTH-1 and row increments. At col=0, row=ROW_NUM-1 -> DRAIN.
  - DRAIN: ren=0; wait 2 cycles for the pipeline to empty -> DONE.
  - DONE: done=1, busy=0 for 1 cycle -> IDLE.
- Pipeline:
  - Stage 1 (cycle t, ren) registers the address and a row-start flag (col==COL_WIDTH-1).
  - Stage 2 (t+1) computes from din.
  - Stage 3 (t+2) registers dout, wen=1, waddr=raddr(t).
  - Latency ren->wen = 2 cycles; throughput 1 word/cycle; no bubbles between rows.
- Arithmetic, per lane:
  - out[i] = in[i+1] - in[i] for i<PORT_SIZE-1.
  - out[P-1] = prev - in[P-1].
  - Computed at DATA_W+1 bits, then reduced to DATA_W (saturate or wrap; see Optional Feature).
  - prev <= in[0] on each valid word.
- Row start: for the first word of a row (col=COL_WIDTH-1), prev is not used. Lane P-1 gives -in[P-1] (BOUNDARY=0) or exactly 0 (BOUNDARY=1).
- Boundary conditions:
  - start while busy is ignored, and f_num changes while busy have no effect.
  - start in the same cycle as rst: reset wins.
  - rst mid-frame returns to IDLE immediately. No further ren/wen after the reset cycle, and no done pulse.
  - ROW_NUM*COL_WIDTH=1 is legal: READ lasts one cycle.
- Total: start accepted at cycle 0 -> ren cycles 1..N (N=ROW_NUM*COL_WIDTH) -> wen cycles 3..N+2 -> done at N+3.

Optional Feature:
- Macro: TV_GRAD_SAT_EN.
- Defined: results outside [-2^(DATA_W-1), 2^(DATA_W-1)-1] clamp to the nearest limit.
- Undefined: the result is the low DATA_W bits (two's-complement wrap), with no clamp logic.

Test Plan:
All scenarios use PORT_SIZE=4, DATA_W=16, COL_WIDTH=2, ROW_NUM=3.
1. Addressing: f_num=2, start -> raddr sequence 13,12,15,14,17,16 on 6 consecutive cycles; waddr is the same sequence 2 cycles later; done pulses once, at cycle 9.
2. dx, BOUNDARY=0: row0 col1 lanes0..3 = {10,20,30,40}, col0 = {1,2,3,4} -> dout col1 = {10,10,10,-40}; col0 = {1,1,1,6}.
3. BOUNDARY=1 with the data of scenario 2 -> col1 lane3 = 0; all other lanes unchanged.
4. Overflow: lane0=-32768, lane1=32767 -> lane0 out = 32767 with TV_GRAD_SAT_EN defined; 0xFFFF (-1) without it.
5. Row chaining: verify that prev resets at every row start (row1 col1 lane3 = -in[3]) and never carries over from the previous row's col0.
6. Control: start pulsed while busy -> ignored. rst asserted at cycle 4 -> wen low from cycle 5, busy=0, no done. A new start afterwards completes normally.
